// File: rtl/rx_unit_pkg.sv
// Shared MiniUart receive definitions: FSM encoding, default sizing and sample-point helpers.
// UART_RX_MAJORITY_EN moves the start-bit decision one tick later so that the three-tick vote stays centred.
package rx_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
`else
  localparam int MAJ_DELAY = 0;
`endif

  // The later start decision shifts every later decision by the same tick, so bit timing is unchanged.
  function automatic int mid_start(input int os);
    return os / 2 - 1 + MAJ_DELAY;
  endfunction

  function automatic int mid_bit(input int os);
    return os - 1;
  endfunction

endpackage

// File: rtl/rx_unit_sample.sv
// Input synchronizer for rxd, with an optional 3-tick majority voter (UART_RX_MAJORITY_EN).
// smp_vld strobes on the en_rx tick where cnt equals the decision point dec.
module rx_sample #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  input  logic          en_rx,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] dec,
  output logic          rxd_s,
  output logic          smp,
  output logic          smp_vld
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], rxd};

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;

  assign rxd_s   = sync_q[1];
  assign smp_vld = en_rx && (cnt == dec);

`ifdef UART_RX_MAJORITY_EN
  // Votes captured two ticks and one tick before the decision; the third vote is live.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (en_rx && cnt == dec - CW'(2)) vote_d[0] = rxd_s;
    if (en_rx && cnt == dec - CW'(1)) vote_d[1] = rxd_s;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) vote_q <= 2'b11;
    else     vote_q <= vote_d;

  assign smp = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);
`else
  assign smp = rxd_s;
`endif

endmodule

// File: rtl/rx_unit.sv
// MiniUart receiver: 1 start, DATA_BITS data (LSB first), 1 stop, oversampled by en_rx ticks.
// Optional UART_RX_MAJORITY_EN selects a 3-tick majority vote at each sample point.
module rx_unit
  import rx_unit_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 en_rx,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rs,
  output logic                 fe,
  output logic                 oe,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] START_DEC = CW'(mid_start(OVERSAMPLE));
  localparam logic [CW-1:0] BIT_DEC   = CW'(mid_bit(OVERSAMPLE));
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, dec;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, d_out_q, d_out_d;
  logic                 rs_q, rs_d, fe_q, fe_d, oe_q, oe_d;
  logic                 rxd_s, smp, smp_vld;

  assign dec = (state_q == ST_START) ? START_DEC : BIT_DEC;

  rx_sample #(.CW(CW)) u_sample (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .en_rx   (en_rx),
    .cnt     (cnt_q),
    .dec     (dec),
    .rxd_s   (rxd_s),
    .smp     (smp),
    .smp_vld (smp_vld)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (en_rx) begin
      case (state_q)
        ST_IDLE:  if (!rxd_s) state_d = ST_START;
        ST_START: if (smp_vld) state_d = smp ? ST_IDLE : ST_DATA;
        ST_DATA:  if (smp_vld && bcnt_q == LAST_BIT) state_d = ST_STOP;
        ST_STOP:  if (smp_vld) state_d = smp ? ST_IDLE : ST_BREAK;
        ST_BREAK: if (rxd_s) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

  // clr is applied first so a completion in the same cycle overrides it.
  always_comb begin
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    d_out_d = d_out_q;
    rs_d    = clr ? 1'b0 : rs_q;
    fe_d    = clr ? 1'b0 : fe_q;
    oe_d    = clr ? 1'b0 : oe_q;
    if (en_rx) begin
      case (state_q)
        ST_START: begin
          cnt_d = smp_vld ? '0 : cnt_q + CW'(1);
          if (smp_vld) bcnt_d = '0;
        end
        ST_DATA: begin
          if (smp_vld) begin
            shreg_d = DATA_BITS'({smp, shreg_q} >> 1);
            cnt_d   = '0;
            bcnt_d  = (bcnt_q == LAST_BIT) ? '0 : bcnt_q + BW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (smp_vld) begin
            cnt_d   = '0;
            d_out_d = shreg_q;
            rs_d    = 1'b1;
            fe_d    = ~smp;
            oe_d    = oe_d | rs_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      d_out_q <= '0;
      rs_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      d_out_q <= d_out_d;
      rs_q    <= rs_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end

  assign d_out = d_out_q;
  assign rs    = rs_q;
  assign fe    = fe_q;
  assign oe    = oe_q;

endmodule

// File: tb/tb_rx_unit.sv
// Scoreboard bench for rx_unit: en_rx every 4 clks, OVERSAMPLE=16, frames driven tick by tick.
module tb_rx_unit;

  logic       clk = 1'b0;
  logic       rst, rxd, en_rx, clr;
  logic [7:0] d_out;
  logic       rs, fe, oe, busy;

  always #5 clk = ~clk;

  rx_unit #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .en_rx(en_rx), .clr(clr),
    .d_out(d_out), .rs(rs), .fe(fe), .oe(oe), .busy(busy)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam int STOP_T = 153;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int STOP_T = 152;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       oe;
  } exp_t;

  exp_t sb[$];
  int   errs = 0, checks = 0;
  logic m_rs = 1'b0, m_oe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One en_rx tick; rxd set before the call is what this tick sees after synchronization.
  task automatic tick(input logic c);
    repeat (3) @(negedge clk);
    en_rx = 1'b1;
    clr   = c;
    @(negedge clk);
    en_rx = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    m_rs = 1'b0;
    m_oe = 1'b0;
    chk("clr_rs", rs, 0);
    chk("clr_fe", fe, 0);
    chk("clr_oe", oe, 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_t,
                            input int stop_ticks, input logic clr_at_stop, input logic [7:0] exp_d);
    exp_t e, got;
    logic v;
    e.d  = exp_d;
    e.fe = ~stop;
    e.oe = (clr_at_stop ? 1'b0 : m_oe) | m_rs;
    sb.push_back(e);
    m_rs = 1'b1;
    m_oe = e.oe;
    for (int t = 0; t < 144 + stop_ticks; t++) begin
      if (t < 16)       v = 1'b0;
      else if (t < 144) v = d[(t - 16) / 16];
      else              v = stop;
      if (t == glitch_t) v = ~v;
      rxd = v;
      if (t == STOP_T) begin
        tick(clr_at_stop);
        got = sb.pop_front();
        chk("d_out", d_out, got.d);
        chk("rs", rs, 1);
        chk("fe", fe, got.fe);
        chk("oe", oe, got.oe);
        chk("busy_end", busy, stop ? 0 : 1);
      end else begin
        tick(1'b0);
        if (t == STOP_T - 1) chk("busy_pre", busy, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; en_rx = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_d", d_out, 0);
    chk("rst_rs", rs, 0);
    chk("rst_fe", fe, 0);
    chk("rst_oe", oe, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(4);

    send_frame(8'h55, 1'b1, -1, 16, 1'b0, 8'h55);
    do_clr();

    // Short low glitch: START must abort at the mid sample.
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("glitch_busy", busy, 1);
    idle(12);
    chk("glitch_idle", busy, 0);
    chk("glitch_rs", rs, 0);

    send_frame(8'hA3, 1'b0, -1, 40, 1'b0, 8'hA3);
    chk("break_busy", busy, 1);
    idle(3);
    chk("break_exit", busy, 0);
    chk("break_d", d_out, 8'hA3);
    chk("break_rs", rs, 1);
    do_clr();

    send_frame(8'h12, 1'b1, -1, 16, 1'b0, 8'h12);
    send_frame(8'h34, 1'b1, -1, 16, 1'b0, 8'h34);
    do_clr();
    send_frame(8'h56, 1'b1, -1, 16, 1'b0, 8'h56);
    send_frame(8'h78, 1'b1, -1, 16, 1'b1, 8'h78);

    // Reset mid-frame at bit 4 of 0xFF while rs and oe are still set.
    rxd = 1'b0;
    for (int t = 0; t < 16 + 16 * 4 + 8; t++) begin
      rxd = (t < 16) ? 1'b0 : 1'b1;
      tick(1'b0);
    end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mrst_d", d_out, 0);
    chk("mrst_rs", rs, 0);
    chk("mrst_oe", oe, 0);
    chk("mrst_busy", busy, 0);
    rxd = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    m_rs = 1'b0;
    m_oe = 1'b0;
    idle(4);
    send_frame(8'h0F, 1'b1, -1, 16, 1'b0, 8'h0F);
    do_clr();

    send_frame(8'h00, 1'b1, 56, 16, 1'b0, GLITCH_EXP);
    idle(2);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
